// File: rtl/knn_pkg.sv
// Shared widths and types for the kNN query issuer and its tracking buffer.
package knn_pkg;

    localparam int DATA_W    = 64;
    localparam int NUM_SV    = 8;
    localparam int IDX_W     = 3;
    localparam int TAG_W     = 8;
    localparam int RES_DEPTH = 16;

    typedef logic [IDX_W-1:0] sv_idx_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        sv_idx_t          addr_1st;
        sv_idx_t          addr_2nd;
    } res_entry_t;

endpackage

// File: rtl/knn_track_buf.sv
// Three-pointer circular buffer: alloc reserves a slot with its tag, comp fills
// in the dist_sort result, rd retires the head. Pointer MSB marks wrap.
module knn_track_buf
    import knn_pkg::*;
#(
    parameter int DEPTH = RES_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_alloc,
    input  logic [TAG_W-1:0] i_alloc_tag,
    input  logic             i_comp,
    input  sv_idx_t          i_comp_a1,
    input  sv_idx_t          i_comp_a2,
    input  logic             i_rd,
    output logic             o_full,
    output logic             o_inflight_nz,
    output logic             o_valid,
    output res_entry_t       o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] r_alloc;
    logic [PW-1:0] r_comp;
    logic [PW-1:0] r_rd;
    logic [PW-1:0] w_occ;
    logic [PW-1:0] w_infl;
    logic          w_alloc_ok;
    logic          w_comp_ok;
    logic          w_rd_ok;
    res_entry_t    r_mem [DEPTH];

    // Modulo-2^PW subtraction gives correct counts across wrap.
    assign w_occ         = r_alloc - r_rd;
    assign w_infl        = r_alloc - r_comp;
    assign o_full        = (w_occ == PW'(DEPTH));
    assign o_inflight_nz = (w_infl != '0);
    assign o_valid       = (r_comp != r_rd);
    assign o_head        = r_mem[r_rd[AW-1:0]];

    assign w_alloc_ok = i_alloc & ~o_full;
    assign w_comp_ok  = i_comp & o_inflight_nz;
    assign w_rd_ok    = i_rd & o_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alloc <= '0;
            r_comp  <= '0;
            r_rd    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_alloc_ok) begin
                r_mem[r_alloc[AW-1:0]].tag <= i_alloc_tag;
                r_alloc                    <= r_alloc + PW'(1);
            end
            if (w_comp_ok) begin
                r_mem[r_comp[AW-1:0]].addr_1st <= i_comp_a1;
                r_mem[r_comp[AW-1:0]].addr_2nd <= i_comp_a2;
                r_comp                         <= r_comp + PW'(1);
            end
            if (w_rd_ok) begin
                r_rd <= r_rd + PW'(1);
            end
        end
    end

endmodule

// File: rtl/knn_query_issuer.sv
// Front end for dist_sort: owns the search-vector bank, issues tagged queries
// under credit control and returns results in issue order.
module knn_query_issuer
    import knn_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sv_wr_en,
    input  sv_idx_t                  sv_wr_idx,
    input  logic [DATA_W-1:0]        sv_wr_data,
    output logic                     sv_wr_ready,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [DATA_W-1:0]        q_data,
    input  logic [TAG_W-1:0]         q_tag,
    output logic                     ds_in_valid,
    output logic [DATA_W-1:0]        ds_query,
    output logic [NUM_SV*DATA_W-1:0] ds_search,
    input  logic                     ds_out_valid,
    input  sv_idx_t                  ds_addr_1st,
    input  sv_idx_t                  ds_addr_2nd,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic [TAG_W-1:0]         r_tag,
    output sv_idx_t                  r_addr_1st,
    output sv_idx_t                  r_addr_2nd,
    output logic                     busy,
    output logic                     err_unexpected
);

    logic              r_run;
    logic              r_ds_valid;
    logic [DATA_W-1:0] r_ds_query;
    logic              r_err;
    logic              w_full;
    logic              w_infl_nz;
    logic              w_fire;
    logic              w_wr_fire;
    res_entry_t        w_head;

    // Handshakes stay closed while reset is held and until the first edge after release.
    assign q_ready     = r_run & ~w_full & ~sv_wr_en;
    assign w_fire      = q_valid & q_ready;
    assign sv_wr_ready = r_run & ~w_infl_nz & ~w_fire;
    assign w_wr_fire   = sv_wr_en & sv_wr_ready;

    assign busy           = w_infl_nz;
    assign err_unexpected = r_err;
    assign ds_in_valid    = r_ds_valid;
    assign ds_query       = r_ds_query;

    assign r_tag      = w_head.tag;
    assign r_addr_1st = w_head.addr_1st;
    assign r_addr_2nd = w_head.addr_2nd;

    for (genvar gi = 0; gi < NUM_SV; gi++) begin : g_bank
        logic [DATA_W-1:0] r_entry;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_entry <= '0;
            end else if (w_wr_fire && (sv_wr_idx == sv_idx_t'(gi))) begin
                r_entry <= sv_wr_data;
            end
        end

        assign ds_search[gi*DATA_W +: DATA_W] = r_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_ds_valid <= 1'b0;
            r_ds_query <= '0;
            r_err      <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_ds_valid <= w_fire;
            if (w_fire) begin
                r_ds_query <= q_data;
            end
            // dist_sort cannot be stalled, so a result with no owner is only flagged.
            if (ds_out_valid && !w_infl_nz) begin
                r_err <= 1'b1;
            end
        end
    end

    knn_track_buf #(
        .DEPTH(RES_DEPTH)
    ) u_track_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_alloc      (w_fire),
        .i_alloc_tag  (q_tag),
        .i_comp       (ds_out_valid),
        .i_comp_a1    (ds_addr_1st),
        .i_comp_a2    (ds_addr_2nd),
        .i_rd         (r_ready),
        .o_full       (w_full),
        .o_inflight_nz(w_infl_nz),
        .o_valid      (r_valid),
        .o_head       (w_head)
    );

endmodule

// File: tb/tb_knn_query_issuer.sv
// Directed bench for knn_query_issuer with a fixed-latency dist_sort stand-in.
module tb_knn_query_issuer;
    import knn_pkg::*;

    localparam int P = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     sv_wr_en;
    sv_idx_t                  sv_wr_idx;
    logic [DATA_W-1:0]        sv_wr_data;
    logic                     sv_wr_ready;
    logic                     q_valid;
    logic                     q_ready;
    logic [DATA_W-1:0]        q_data;
    logic [TAG_W-1:0]         q_tag;
    logic                     ds_in_valid;
    logic [DATA_W-1:0]        ds_query;
    logic [NUM_SV*DATA_W-1:0] ds_search;
    logic                     ds_out_valid;
    sv_idx_t                  ds_addr_1st;
    sv_idx_t                  ds_addr_2nd;
    logic                     r_valid;
    logic                     r_ready;
    logic [TAG_W-1:0]         r_tag;
    sv_idx_t                  r_addr_1st;
    sv_idx_t                  r_addr_2nd;
    logic                     busy;
    logic                     err_unexpected;

    int checks  = 0;
    int errors  = 0;
    int drained = 0;
    res_entry_t expq[$];

    always #5 clk = ~clk;

    knn_query_issuer dut (
        .clk(clk), .rst_n(rst_n),
        .sv_wr_en(sv_wr_en), .sv_wr_idx(sv_wr_idx), .sv_wr_data(sv_wr_data), .sv_wr_ready(sv_wr_ready),
        .q_valid(q_valid), .q_ready(q_ready), .q_data(q_data), .q_tag(q_tag),
        .ds_in_valid(ds_in_valid), .ds_query(ds_query), .ds_search(ds_search),
        .ds_out_valid(ds_out_valid), .ds_addr_1st(ds_addr_1st), .ds_addr_2nd(ds_addr_2nd),
        .r_valid(r_valid), .r_ready(r_ready), .r_tag(r_tag),
        .r_addr_1st(r_addr_1st), .r_addr_2nd(r_addr_2nd),
        .busy(busy), .err_unexpected(err_unexpected)
    );

    // dist_sort stand-in: P-cycle pipeline, answer derived from query bits; not reset.
    logic [P-1:0]      m_v = '0;
    logic [DATA_W-1:0] m_q [P];
    logic              inj = 1'b0;

    always @(posedge clk) begin
        m_v    <= {m_v[P-2:0], ds_in_valid};
        m_q[0] <= ds_query;
        for (int i = 1; i < P; i++) m_q[i] <= m_q[i-1];
    end

    assign ds_out_valid = m_v[P-1] | inj;
    assign ds_addr_1st  = m_q[P-1][2:0] ^ 3'd3;
    assign ds_addr_2nd  = m_q[P-1][5:3] ^ 3'd1;

    function automatic res_entry_t exp_res(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] q);
        res_entry_t r;
        r.tag      = t;
        r.addr_1st = q[2:0] ^ 3'd3;
        r.addr_2nd = q[5:3] ^ 3'd1;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Called with inputs settled mid-cycle; scores the drain and issue, then moves to next negedge.
    task automatic tick(output bit fired);
        res_entry_t got;
        fired = q_valid & q_ready;
        if (r_valid && r_ready) begin
            got = {r_tag, r_addr_1st, r_addr_2nd};
            check("result_expected", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) check("result_order", 64'(got), 64'(expq.pop_front()));
            drained++;
        end
        if (fired) expq.push_back(exp_res(q_tag, q_data));
        @(negedge clk);
    endtask

    task automatic drain_all(input int budget);
        bit f;
        int n = 0;
        #1;
        while (expq.size() != 0 && n < budget) begin
            tick(f);
            #1;
            n++;
        end
        check("drain_empty", 64'(expq.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bit f;
        int k;
        int n;
        int d0;

        rst_n = 1'b1; sv_wr_en = 0; sv_wr_idx = '0; sv_wr_data = '0;
        q_valid = 0; q_data = '0; q_tag = '0; r_ready = 0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_q_ready", q_ready, 0);
        check("rst_sv_wr_ready", sv_wr_ready, 0);
        check("rst_r_valid", r_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ds_in_valid", ds_in_valid, 0);
        check("rst_ds_query", ds_query, 0);
        check("rst_err", err_unexpected, 0);
        check("rst_bank0", ds_search[0 +: 64], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Load bank[i] = i+1
        for (int i = 0; i < NUM_SV; i++) begin
            sv_wr_en = 1; sv_wr_idx = sv_idx_t'(i); sv_wr_data = 64'(i + 1);
            #1;
            check("wr_ready_idle", sv_wr_ready, 1);
            tick(f);
        end
        sv_wr_en = 0;
        #1;
        for (int i = 0; i < NUM_SV; i++) check("bank_load", ds_search[i*DATA_W +: DATA_W], 64'(i + 1));

        // Single query, tag 05
        q_valid = 1; q_data = '0; q_tag = 8'h05;
        #1;
        check("q1_ready", q_ready, 1);
        check("q1_in_valid_pre", ds_in_valid, 0);
        tick(f);
        q_valid = 0;
        #1;
        check("q1_in_valid", ds_in_valid, 1);
        check("q1_query", ds_query, 0);
        check("q1_busy", busy, 1);
        tick(f);
        #1;
        check("q1_in_valid_drop", ds_in_valid, 0);
        n = 0;
        while (!r_valid && n < 20) begin tick(f); #1; n++; end
        check("q1_r_valid", r_valid, 1);
        check("q1_r_tag", r_tag, 8'h05);
        check("q1_a1", r_addr_1st, 3);
        check("q1_a2", r_addr_2nd, 1);
        r_ready = 1;
        tick(f);
        r_ready = 0;
        #1;
        check("q1_r_valid_after", r_valid, 0);
        check("q1_busy_after", busy, 0);

        // Fill 16 with r_ready low, then drain while the rest go in
        k = 0;
        for (int c = 0; c < 30; c++) begin
            q_valid = 1; q_data = 64'(k); q_tag = 8'(k);
            #1;
            tick(f);
            if (f) k++;
        end
        check("fill_accepted", 64'(k), 16);
        #1;
        check("full_q_ready", q_ready, 0);
        r_ready = 1;
        #1;
        check("full_drain_q_ready", q_ready, 0);
        d0 = drained;
        tick(f);
        n = 0;
        while ((k < 20 || expq.size() != 0) && n < 200) begin
            q_valid = (k < 20); q_data = 64'(k); q_tag = 8'(k);
            #1;
            tick(f);
            if (f) k++;
            n++;
        end
        q_valid = 0;
        check("stream_issued", 64'(k), 20);
        check("stream_drained", 64'(drained - d0), 20);
        check("stream_queue_empty", 64'(expq.size()), 0);

        // Bank write held off while two queries are inflight
        q_valid = 1; q_data = 64'h20; q_tag = 8'h20;
        #1; tick(f);
        q_data = 64'h21; q_tag = 8'h21;
        #1; tick(f);
        q_valid = 0; sv_wr_en = 1; sv_wr_idx = 3'd2; sv_wr_data = 64'hAA;
        #1;
        check("wr_blocked", sv_wr_ready, 0);
        check("wr_blocked_busy", busy, 1);
        n = 0;
        while (!sv_wr_ready && n < 20) begin
            check("bank_hold", ds_search[2*DATA_W +: DATA_W], 3);
            tick(f);
            #1;
            n++;
        end
        check("wr_unblocked", sv_wr_ready, 1);
        check("wr_unblocked_busy", busy, 0);
        tick(f);
        sv_wr_en = 0;
        #1;
        check("bank_written", ds_search[2*DATA_W +: DATA_W], 64'hAA);
        drain_all(30);

        // Bank write and query together while idle
        sv_wr_en = 1; sv_wr_idx = 3'd5; sv_wr_data = 64'h55;
        q_valid = 1; q_data = 64'h30; q_tag = 8'h30;
        #1;
        check("both_q_ready", q_ready, 0);
        check("both_wr_ready", sv_wr_ready, 1);
        tick(f);
        sv_wr_en = 0;
        #1;
        check("both_bank5", ds_search[5*DATA_W +: DATA_W], 64'h55);
        check("both_q_ready_next", q_ready, 1);
        tick(f);
        q_valid = 0;
        #1;
        check("both_in_valid", ds_in_valid, 1);
        check("both_query", ds_query, 64'h30);
        drain_all(30);

        // Unexpected out_valid
        #1;
        check("unexp_err_pre", err_unexpected, 0);
        check("unexp_busy_pre", busy, 0);
        inj = 1;
        tick(f);
        inj = 0;
        #1;
        check("unexp_err", err_unexpected, 1);
        check("unexp_r_valid", r_valid, 0);
        for (int i = 0; i < 3; i++) tick(f);
        #1;
        check("unexp_err_sticky", err_unexpected, 1);
        check("unexp_r_valid_later", r_valid, 0);

        // Reset with 2 buffered and 3 inflight
        r_ready = 0;
        q_valid = 1; q_data = 64'h40; q_tag = 8'h40;
        #1; tick(f);
        q_data = 64'h41; q_tag = 8'h41;
        #1; tick(f);
        q_valid = 0;
        for (int i = 0; i < 8; i++) begin #1; tick(f); end
        #1;
        check("rst2_buffered", r_valid, 1);
        q_valid = 1; q_data = 64'h42; q_tag = 8'h42;
        #1; tick(f);
        q_data = 64'h43; q_tag = 8'h43;
        #1; tick(f);
        q_data = 64'h44; q_tag = 8'h44;
        #1; tick(f);
        q_valid = 0;
        #1; tick(f);
        #1;
        check("rst2_busy_pre", busy, 1);
        rst_n = 0;
        #1;
        check("rst2_r_valid", r_valid, 0);
        check("rst2_busy", busy, 0);
        check("rst2_in_valid", ds_in_valid, 0);
        check("rst2_err_clear", err_unexpected, 0);
        rst_n = 1;
        expq.delete();
        for (int i = 0; i < 6; i++) tick(f);
        #1;
        check("rst2_late_err", err_unexpected, 1);
        check("rst2_r_valid_late", r_valid, 0);
        check("rst2_busy_late", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
